// File: rtl/shift_window_ctrl.sv
// shift_window_ctrl
// Sequencer that turns an external 5-slot shift register into a sliding
// sample window. It accepts a valid/ready sample stream and drives the
// register's shift enable. Once enough new samples have arrived, it freezes
// the register and offers the window downstream. After each accepted window,
// the next one needs a programmable number (stride) of fresh samples.
module shift_window_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [2:0]       cfg_stride,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             shift_enable,
  output logic [WIDTH-1:0] sr_data_in,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [2:0]       fill_count,
  output logic [CNT_W-1:0] win_count
);

  localparam logic [2:0] DEPTH_3 = 3'(DEPTH);

  typedef enum logic {
    FILL   = 1'b0,
    WINDOW = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [2:0]       need_cnt_r, need_cnt_s;
  logic [2:0]       fill_count_r, fill_count_s;
  logic             win_valid_r, win_valid_s;
  logic [CNT_W-1:0] win_count_r, win_count_s;
  logic [2:0]       stride_r, stride_s;
  logic             accept_s;

  // Map a raw stride request onto the legal range 1..DEPTH.
  function automatic logic [2:0] clamp_stride(input logic [2:0] raw);
    logic [2:0] res;
    if (raw == 3'd0) begin
      res = 3'd1;
    end else if (raw > DEPTH_3) begin
      res = DEPTH_3;
    end else begin
      res = raw;
    end
    return res;
  endfunction

  // Input side: samples flow straight into the shift register whenever we are filling.
  always_comb begin
    in_ready     = (state_r == FILL) & ~flush & ~rst;
    shift_enable = in_valid & in_ready;
    sr_data_in   = in_data;
    accept_s     = win_valid_r & win_ready;
  end

  // Next-state logic: flush discards any window; otherwise fill or wait for the consumer.
  always_comb begin
    state_s      = state_r;
    need_cnt_s   = need_cnt_r;
    fill_count_s = fill_count_r;
    win_valid_s  = win_valid_r;
    win_count_s  = win_count_r;
    stride_s     = stride_r;
    if (flush) begin
      state_s      = FILL;
      need_cnt_s   = DEPTH_3;
      fill_count_s = 3'd0;
      win_valid_s  = 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (shift_enable) begin
            fill_count_s = (fill_count_r >= DEPTH_3) ? DEPTH_3 : fill_count_r + 3'd1;
            need_cnt_s   = need_cnt_r - 3'd1;
            if (need_cnt_r == 3'd1) begin
              state_s     = WINDOW;
              win_valid_s = 1'b1;
            end else begin
              state_s     = FILL;
            end
          end else begin
            state_s = FILL;
          end
        end
        WINDOW: begin
          if (accept_s) begin
            state_s     = FILL;
            win_valid_s = 1'b0;
            win_count_s = win_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            stride_s    = clamp_stride(cfg_stride);
            need_cnt_s  = clamp_stride(cfg_stride);
          end else begin
            state_s = WINDOW;
          end
        end
        default: begin
          state_s      = FILL;
          need_cnt_s   = DEPTH_3;
          fill_count_s = 3'd0;
          win_valid_s  = 1'b0;
        end
      endcase
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FILL;
      need_cnt_r   <= DEPTH_3;
      fill_count_r <= 3'd0;
      win_valid_r  <= 1'b0;
      win_count_r  <= {CNT_W{1'b0}};
      stride_r     <= 3'd1;
    end else begin
      state_r      <= state_s;
      need_cnt_r   <= need_cnt_s;
      fill_count_r <= fill_count_s;
      win_valid_r  <= win_valid_s;
      win_count_r  <= win_count_s;
      stride_r     <= stride_s;
    end
  end

  assign win_valid  = win_valid_r;
  assign fill_count = fill_count_r;
  assign win_count  = win_count_r;

endmodule

// File: tb/tb_shift_window_ctrl.sv
// Testbench for shift_window_ctrl: directed scenarios followed by random
// traffic, all checked against a sample-counting reference model.
module tb_shift_window_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [2:0]  cfg_stride;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        shift_enable;
  logic [7:0]  sr_data_in;
  logic        win_valid;
  logic        win_ready;
  logic [2:0]  fill_count;
  logic [15:0] win_count;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model
  bit          m_init = 0;
  bit          m_wv;
  int          m_need;
  int          m_fill;
  int          m_stride;
  logic [15:0] m_wc;
  logic [7:0]  m_q[$];
  // bench copy of the external shift register, fed by the DUT's outputs
  logic [7:0]  sr[5];

  shift_window_ctrl #(.WIDTH(8), .DEPTH(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cfg_stride(cfg_stride),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .shift_enable(shift_enable), .sr_data_in(sr_data_in),
    .win_valid(win_valid), .win_ready(win_ready),
    .fill_count(fill_count), .win_count(win_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input int a, input int b, input int c, input int d, input int e);
    int ex[5];
    ex = '{a, b, c, d, e};
    for (int i = 0; i < 5; i++) chk(tag, {24'd0, sr[i]}, ex[i]);
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model on the edge.
  task automatic cyc(input logic r, input logic f, input logic v, input logic [7:0] d,
                     input logic wr, input logic [2:0] cs);
    logic       exp_ready;
    logic       exp_shift;
    logic       got_shift;
    logic [7:0] got_data;
    int         s;
    rst = r; flush = f; in_valid = v; in_data = d; win_ready = wr; cfg_stride = cs;
    #1;
    got_shift = shift_enable;
    got_data  = sr_data_in;
    if (m_init) begin
      exp_ready = !m_wv && !f && !r;
      exp_shift = v && exp_ready;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      chk("shift_enable", {31'd0, shift_enable}, {31'd0, exp_shift});
      chk("win_valid", {31'd0, win_valid}, {31'd0, m_wv});
      chk("fill_count", {29'd0, fill_count}, m_fill);
      chk("win_count", {16'd0, win_count}, {16'd0, m_wc});
      if (exp_shift) chk("sr_data_in", {24'd0, sr_data_in}, {24'd0, d});
      if (m_wv && m_q.size() == 5) begin
        for (int i = 0; i < 5; i++) chk("window_slot", {24'd0, sr[i]}, {24'd0, m_q[i]});
      end
    end
    @(posedge clk);
    if (got_shift === 1'b1) begin
      for (int i = 0; i < 4; i++) sr[i] = sr[i+1];
      sr[4] = got_data;
    end
    if (r) begin
      m_init = 1; m_wv = 0; m_need = 5; m_fill = 0; m_stride = 1; m_wc = 16'd0;
    end else if (m_init) begin
      if (f) begin
        m_wv = 0; m_need = 5; m_fill = 0;
      end else if (m_wv) begin
        if (wr) begin
          s = (cs == 3'd0) ? 1 : ((cs > 3'd5) ? 5 : int'(cs));
          m_wv = 0; m_wc = m_wc + 16'd1; m_stride = s; m_need = s;
        end
      end else if (v) begin
        m_q.push_back(d);
        if (m_q.size() > 5) void'(m_q.pop_front());
        m_fill = (m_fill + 1 > 5) ? 5 : m_fill + 1;
        m_need = m_need - 1;
        if (m_need == 0) m_wv = 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'd0; win_ready = 1'b0; cfg_stride = 3'd0;

    // T1 reset
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t1_win_valid", {31'd0, win_valid}, 32'd0);
    chk("t1_fill", {29'd0, fill_count}, 32'd0);
    chk("t1_wcount", {16'd0, win_count}, 32'd0);

    // T2 fill with 1..5
    for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 3'd0);
    chk("t2_win_valid", {31'd0, win_valid}, 32'd1);
    chk("t2_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t2_fill", {29'd0, fill_count}, 32'd5);
    chk_win("t2_window", 1, 2, 3, 4, 5);

    // T3 stall with input offered
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 8'd9, 1'b0, 3'd0);
    chk("t3_win_valid", {31'd0, win_valid}, 32'd1);
    chk_win("t3_window", 1, 2, 3, 4, 5);

    // T4 stride 2, then stride 0 (clamped to 1)
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd2);
    cyc(1'b0, 1'b0, 1'b1, 8'd6, 1'b0, 3'd2);
    chk("t4_mid_valid", {31'd0, win_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 3'd2);
    chk("t4_wcount", {16'd0, win_count}, 32'd1);
    chk("t4_win_valid", {31'd0, win_valid}, 32'd1);
    chk_win("t4_window", 3, 4, 5, 6, 7);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'd8, 1'b0, 3'd0);
    chk("t4_s0_valid", {31'd0, win_valid}, 32'd1);
    chk_win("t4_s0_window", 4, 5, 6, 7, 8);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'd9, 1'b0, 3'd0);
    chk("t4_s0b_valid", {31'd0, win_valid}, 32'd1);
    chk("t4_s0b_wcount", {16'd0, win_count}, 32'd3);
    chk_win("t4_s0b_window", 5, 6, 7, 8, 9);

    // T5 flush mid-fill (stride 7 clamps to 5)
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd7);
    for (int i = 10; i <= 12; i++) cyc(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 3'd0);
    chk("t5_pre_fill", {29'd0, fill_count}, 32'd5);
    cyc(1'b0, 1'b1, 1'b1, 8'd99, 1'b0, 3'd0);
    chk("t5_fill", {29'd0, fill_count}, 32'd0);
    chk("t5_wcount", {16'd0, win_count}, 32'd4);
    for (int i = 13; i <= 16; i++) cyc(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 3'd0);
    chk("t5_no_valid", {31'd0, win_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'd17, 1'b0, 3'd0);
    chk("t5_valid", {31'd0, win_valid}, 32'd1);
    chk_win("t5_window", 13, 14, 15, 16, 17);

    // flush coinciding with win_ready drops the window
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 3'd1);
    chk("flush_drop_wcount", {16'd0, win_count}, 32'd4);
    chk("flush_drop_valid", {31'd0, win_valid}, 32'd0);
    for (int i = 20; i <= 24; i++) cyc(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 3'd0);

    // T6 reset while a window is pending
    chk("t6_pre_valid", {31'd0, win_valid}, 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 3'd0);
    chk("t6_win_valid", {31'd0, win_valid}, 32'd0);
    chk("t6_wcount", {16'd0, win_count}, 32'd0);
    chk("t6_fill", {29'd0, fill_count}, 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 3) != 0),
          8'($urandom),
          1'($urandom_range(0, 2) == 0),
          3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
